// File: rtl/pmm_pkg.sv
// Shared constants and types for the PMM host-side sequencer.
package pmm_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_SCAN = 2'b10;
  localparam logic [1:0] OP_RST  = 2'b11;

  localparam int unsigned MEM_DEPTH = 517;

  // Mask-memory region bases, in 64-bit word indices
  localparam int unsigned REP_POS_BASE = 0;
  localparam int unsigned MOVE_BASE    = 256;
  localparam int unsigned EPS_BEG_BASE = 512;
  localparam int unsigned EPS_BLK_BASE = 513;
  localparam int unsigned EPS_END_BASE = 514;
  localparam int unsigned INIT_BASE    = 515;
  localparam int unsigned ACCEPT_BASE  = 516;

  typedef enum logic [2:0] {
    ST_BOOT_ISSUE,
    ST_BOOT_GAP,
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'd8) ? 4'd8 : len;
  endfunction

endpackage

// File: rtl/pmm_sequencer_if.sv
// Host command channel (valid/ready) into the PMM sequencer.
interface pmm_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [13:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [3:0]  cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
                  output cmd_ready);
endinterface

// File: rtl/pmm_match_tracker.sv
// Character/match counters with saturation and first-match capture.
module pmm_match_tracker #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sample,
  input  logic             i_hit,
  input  logic             i_clear,
  output logic             o_match_pulse,
  output logic [CNT_W-1:0] o_match_pos,
  output logic             o_first_valid,
  output logic [CNT_W-1:0] o_first_pos,
  output logic [CNT_W-1:0] o_char_cnt,
  output logic [CNT_W-1:0] o_match_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_match_pulse <= 1'b0;
      o_match_pos   <= '0;
      o_first_valid <= 1'b0;
      o_first_pos   <= '0;
      o_char_cnt    <= '0;
      o_match_cnt   <= '0;
    end else begin
      o_match_pulse <= 1'b0;
      if (i_clear) begin
        o_char_cnt    <= '0;
        o_match_cnt   <= '0;
        o_first_valid <= 1'b0;
        o_first_pos   <= '0;
      end else if (i_sample) begin
        o_char_cnt <= sat_inc(o_char_cnt);
        if (i_hit) begin
          o_match_pulse <= 1'b1;
          o_match_pos   <= o_char_cnt;
          o_match_cnt   <= sat_inc(o_match_cnt);
          if (!o_first_valid) begin
            o_first_valid <= 1'b1;
            o_first_pos   <= o_char_cnt;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pmm_sequencer.sv
// Serialises host commands into single-cycle PMM transactions and tracks matches.
module pmm_sequencer #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MEM_DEPTH = pmm_pkg::MEM_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  pmm_sequencer_if.slave   cmd,
  output logic [63:0]      pmm_data,
  output logic [15:0]      pmm_ctrl,
  output logic             pmm_valid,
  input  logic             pmm_accept,
  output logic             busy,
  output logic             cfg_err,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_pos,
  output logic             first_valid,
  output logic [CNT_W-1:0] first_pos,
  output logic [CNT_W-1:0] char_cnt,
  output logic [CNT_W-1:0] match_cnt
);
  import pmm_pkg::*;

  state_t      r_state, w_state_nxt;
  logic        r_live;
  logic [1:0]  r_op, w_op_nxt;
  logic [15:0] r_ctrl, w_ctrl_nxt;
  logic [63:0] r_data, w_data_nxt;
  logic [55:0] r_chars, w_chars_nxt;
  logic [3:0]  r_left, w_left_nxt;
  logic        r_cfg_err, w_cfg_err_nxt;

  logic       w_accept, w_in_range, w_boot, w_sample, w_clear;
  logic [3:0] w_len;

  assign w_accept   = cmd.cmd_valid && cmd.cmd_ready;
  assign w_in_range = 32'(cmd.cmd_addr[13:3]) < MEM_DEPTH;
  assign w_len      = clamp_len(cmd.cmd_len);

  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_ctrl_nxt    = r_ctrl;
    w_data_nxt    = r_data;
    w_chars_nxt   = r_chars;
    w_left_nxt    = r_left;
    w_cfg_err_nxt = 1'b0;
    unique case (r_state)
      ST_BOOT_ISSUE: if (r_live) w_state_nxt = ST_BOOT_GAP;
      ST_BOOT_GAP:   w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (w_accept) begin
          w_op_nxt = cmd.cmd_op;
          unique case (cmd.cmd_op)
            OP_WR: begin
              if (w_in_range) begin
                w_ctrl_nxt  = {OP_WR, cmd.cmd_addr};
                w_data_nxt  = cmd.cmd_data;
                w_state_nxt = ST_ISSUE;
              end else begin
                w_cfg_err_nxt = 1'b1;
              end
            end
            OP_SCAN: begin
              if (w_len != 4'd0) begin
                w_ctrl_nxt  = {OP_SCAN, 14'd0};
                w_data_nxt  = {56'd0, cmd.cmd_data[7:0]};
                w_chars_nxt = cmd.cmd_data[63:8];
                w_left_nxt  = w_len;
                w_state_nxt = ST_ISSUE;
              end
            end
            OP_RST: begin
              w_ctrl_nxt  = {OP_RST, 14'd0};
              w_data_nxt  = '0;
              w_state_nxt = ST_ISSUE;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: w_state_nxt = ST_GAP;
      ST_GAP: begin
        // Next character is shifted in here so pmm_data stays stable across ISSUE/GAP
        if (r_op == OP_SCAN && r_left > 4'd1) begin
          w_data_nxt  = {56'd0, r_chars[7:0]};
          w_chars_nxt = {8'd0, r_chars[55:8]};
          w_left_nxt  = r_left - 4'd1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_ctrl_nxt  = '0;
          w_data_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_BOOT_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_BOOT_ISSUE;
      r_live    <= 1'b0;
      r_op      <= OP_NOP;
      r_ctrl    <= '0;
      r_data    <= '0;
      r_chars   <= '0;
      r_left    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_live    <= 1'b1;
      r_op      <= w_op_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_data    <= w_data_nxt;
      r_chars   <= w_chars_nxt;
      r_left    <= w_left_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  // r_live keeps every output quiet while reset is held and until the first edge after release
  assign w_boot        = r_live && (r_state == ST_BOOT_ISSUE || r_state == ST_BOOT_GAP);
  assign pmm_valid     = (r_state == ST_ISSUE) || (w_boot && r_state == ST_BOOT_ISSUE);
  assign pmm_ctrl      = w_boot ? {OP_RST, 14'd0} : r_ctrl;
  assign pmm_data      = r_data;
  assign busy          = r_live && (r_state != ST_IDLE);
  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign cfg_err       = r_cfg_err;

  assign w_sample = (r_state == ST_GAP) && (r_op == OP_SCAN);
  assign w_clear  = (r_state == ST_GAP) && (r_op == OP_RST);

  pmm_match_tracker #(.CNT_W(CNT_W)) u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sample     (w_sample),
    .i_hit        (pmm_accept),
    .i_clear      (w_clear),
    .o_match_pulse(match_pulse),
    .o_match_pos  (match_pos),
    .o_first_valid(first_valid),
    .o_first_pos  (first_pos),
    .o_char_cnt   (char_cnt),
    .o_match_cnt  (match_cnt)
  );

endmodule

// File: tb/tb_pmm_sequencer.sv
// Directed bench for pmm_sequencer with a tiny PMM stand-in that accepts on "ab".
module tb_pmm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pmm_data;
  logic [15:0] pmm_ctrl;
  logic        pmm_valid;
  logic        pmm_accept;
  logic        busy, cfg_err, match_pulse, first_valid;
  logic [31:0] match_pos, first_pos, char_cnt, match_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pmm_sequencer_if cif();

  pmm_sequencer #(.CNT_W(32), .MEM_DEPTH(517)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cif.slave),
    .pmm_data   (pmm_data),
    .pmm_ctrl   (pmm_ctrl),
    .pmm_valid  (pmm_valid),
    .pmm_accept (pmm_accept),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .match_pulse(match_pulse),
    .match_pos  (match_pos),
    .first_valid(first_valid),
    .first_pos  (first_pos),
    .char_cnt   (char_cnt),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  // PMM stand-in: accepting state after 'b' immediately preceded by 'a'
  logic [7:0] m_prev = 8'h00;
  logic       m_acc  = 1'b0;
  always @(posedge clk) begin
    if (pmm_valid === 1'b1) begin
      if (pmm_ctrl[15:14] == 2'b11) begin
        m_prev <= 8'h00;
        m_acc  <= 1'b0;
      end else if (pmm_ctrl[15:14] == 2'b10) begin
        m_acc  <= (pmm_data[7:0] == 8'h62) && (m_prev == 8'h61);
        m_prev <= pmm_data[7:0];
      end
    end
  end
  assign pmm_accept = m_acc;

  int          n_pulse = 0;
  logic [15:0] last_ctrl = '0;
  logic [63:0] last_data = '0;
  int          n_match = 0;
  int unsigned mpos[$];
  always @(negedge clk) begin
    if (pmm_valid === 1'b1) begin
      n_pulse++;
      last_ctrl = pmm_ctrl;
      last_data = pmm_data;
    end
    if (match_pulse === 1'b1) begin
      n_match++;
      mpos.push_back(match_pos);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [13:0] addr,
                      input logic [63:0] data, input logic [3:0] len);
    int k = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_addr  = addr;
    cif.cmd_data  = data;
    cif.cmd_len   = len;
    while (cif.cmd_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("send_timeout", {63'd0, cif.cmd_ready}, 64'd1);
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    tick();
    while (busy !== 1'b0 && k < 100) begin
      tick();
      k++;
    end
    chk(tag, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, k;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'b00;
    cif.cmd_addr  = '0;
    cif.cmd_data  = '0;
    cif.cmd_len   = '0;

    tick(); tick();
    chk("rst_valid", {63'd0, pmm_valid}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, cif.cmd_ready}, 64'd0);
    chk("rst_charcnt", {32'd0, char_cnt}, 64'd0);

    // Boot sequence after release
    rst_n = 1'b1;
    tick();
    chk("boot_valid",  {63'd0, pmm_valid}, 64'd1);
    chk("boot_ctrl",   {48'd0, pmm_ctrl}, 64'hC000);
    chk("boot_ready0", {63'd0, cif.cmd_ready}, 64'd0);
    tick();
    chk("boot_gap_valid", {63'd0, pmm_valid}, 64'd0);
    chk("boot_gap_ready", {63'd0, cif.cmd_ready}, 64'd0);
    tick();
    chk("boot_ready", {63'd0, cif.cmd_ready}, 64'd1);
    chk("boot_pulses", 64'(n_pulse), 64'd1);

    // Write to ACCEPT word (index 516)
    p0 = n_pulse;
    send(2'b01, 14'd4128, 64'h2, 4'd0);
    tick();
    chk("wr_valid", {63'd0, pmm_valid}, 64'd1);
    chk("wr_ctrl",  {48'd0, pmm_ctrl}, 64'h5020);
    chk("wr_data",  pmm_data, 64'h2);
    tick();
    chk("wr_gap_valid", {63'd0, pmm_valid}, 64'd0);
    chk("wr_gap_ctrl",  {48'd0, pmm_ctrl}, 64'h5020);
    tick();
    chk("wr_idle_ready", {63'd0, cif.cmd_ready}, 64'd1);
    chk("wr_idle_ctrl",  {48'd0, pmm_ctrl}, 64'h0);
    chk("wr_pulses", 64'(n_pulse - p0), 64'd1);

    // Out-of-range index 517
    p0 = n_pulse;
    send(2'b01, 14'd4136, 64'h5, 4'd0);
    tick();
    chk("cfgerr_pulse", {63'd0, cfg_err}, 64'd1);
    chk("cfgerr_busy",  {63'd0, busy}, 64'd0);
    tick();
    chk("cfgerr_clear", {63'd0, cfg_err}, 64'd0);
    chk("cfgerr_nopulse", 64'(n_pulse - p0), 64'd0);

    // No-op command
    send(2'b00, 14'd0, 64'h0, 4'd0);
    tick();
    chk("nop_busy", {63'd0, busy}, 64'd0);
    chk("nop_nopulse", 64'(n_pulse - p0), 64'd0);

    // Remaining table loads: MOVE['a'], MOVE['b'], INIT
    send(2'b01, 14'd2824, 64'h1, 4'd0); wait_idle("ld_a_idle");
    send(2'b01, 14'd2832, 64'h2, 4'd0); wait_idle("ld_b_idle");
    send(2'b01, 14'd4120, 64'h1, 4'd0); wait_idle("ld_init_idle");
    chk("ld_last_ctrl", {48'd0, last_ctrl}, 64'h5018);

    // Scan "xaby"
    p0 = n_pulse;
    mpos.delete();
    send(2'b10, 14'd0, 64'h79626178, 4'd4);
    k = 0;
    tick();
    while (busy === 1'b1 && k < 40) begin
      k++;
      tick();
    end
    chk("xaby_busy_cycles", 64'(k), 64'd8);
    chk("xaby_pulses",  64'(n_pulse - p0), 64'd4);
    chk("xaby_lastdata", last_data, 64'h79);
    chk("xaby_nmatch",  64'(mpos.size()), 64'd1);
    if (mpos.size() > 0) chk("xaby_pos", 64'(mpos[0]), 64'd2);
    chk("xaby_charcnt", {32'd0, char_cnt}, 64'd4);
    chk("xaby_matchcnt", {32'd0, match_cnt}, 64'd1);
    chk("xaby_firstv",  {63'd0, first_valid}, 64'd1);
    chk("xaby_firstpos", {32'd0, first_pos}, 64'd2);

    // Reset state op
    p0 = n_pulse;
    send(2'b11, 14'd0, 64'hFFFF, 4'd0);
    wait_idle("rst1_idle");
    chk("rst1_pulses", 64'(n_pulse - p0), 64'd1);
    chk("rst1_ctrl",   {48'd0, last_ctrl}, 64'hC000);
    chk("rst1_charcnt", {32'd0, char_cnt}, 64'd0);
    chk("rst1_matchcnt", {32'd0, match_cnt}, 64'd0);
    chk("rst1_firstv", {63'd0, first_valid}, 64'd0);

    // Scan "abab"
    mpos.delete();
    send(2'b10, 14'd0, 64'h62616261, 4'd4);
    wait_idle("abab_idle");
    chk("abab_nmatch", 64'(mpos.size()), 64'd2);
    if (mpos.size() > 1) begin
      chk("abab_pos0", 64'(mpos[0]), 64'd1);
      chk("abab_pos1", 64'(mpos[1]), 64'd3);
    end
    chk("abab_matchcnt", {32'd0, match_cnt}, 64'd2);
    chk("abab_firstpos", {32'd0, first_pos}, 64'd1);

    // Zero-length scan
    p0 = n_pulse;
    send(2'b10, 14'd0, 64'h62616261, 4'd0);
    tick();
    chk("len0_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("len0_nopulse", 64'(n_pulse - p0), 64'd0);
    chk("len0_charcnt", {32'd0, char_cnt}, 64'd4);

    // Length 12 clamps to 8
    p0 = n_pulse;
    mpos.delete();
    send(2'b10, 14'd0, 64'h6261626162616261, 4'd12);
    wait_idle("len12_idle");
    chk("len12_pulses", 64'(n_pulse - p0), 64'd8);
    chk("len12_charcnt", {32'd0, char_cnt}, 64'd12);
    chk("len12_matchcnt", {32'd0, match_cnt}, 64'd6);
    if (mpos.size() > 3) chk("len12_pos3", 64'(mpos[3]), 64'd11);
    chk("len12_firstpos", {32'd0, first_pos}, 64'd1);

    // Reset op after matches, then "b" alone must not match
    send(2'b11, 14'd0, 64'h0, 4'd0);
    wait_idle("rst2_idle");
    chk("rst2_matchcnt", {32'd0, match_cnt}, 64'd0);
    chk("rst2_firstv", {63'd0, first_valid}, 64'd0);
    mpos.delete();
    send(2'b10, 14'd0, 64'h62, 4'd1);
    wait_idle("b_idle");
    chk("b_nmatch", 64'(mpos.size()), 64'd0);
    chk("b_charcnt", {32'd0, char_cnt}, 64'd1);
    chk("b_firstv", {63'd0, first_valid}, 64'd0);

    // Async reset in the middle of an 8-character scan
    send(2'b10, 14'd0, 64'h6261626162616261, 4'd8);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_valid", {63'd0, pmm_valid}, 64'd0);
    chk("mid_busy",  {63'd0, busy}, 64'd0);
    chk("mid_charcnt", {32'd0, char_cnt}, 64'd0);
    chk("mid_matchcnt", {32'd0, match_cnt}, 64'd0);
    p0 = n_pulse;
    mpos.delete();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_boot_pulses", 64'(n_pulse - p0), 64'd1);
    chk("mid_boot_ctrl", {48'd0, last_ctrl}, 64'hC000);
    chk("mid_charcnt_after", {32'd0, char_cnt}, 64'd0);
    chk("mid_nmatch", 64'(mpos.size()), 64'd0);
    chk("mid_ready", {63'd0, cif.cmd_ready}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
